// File: rtl/mmx_wb_arbiter_if.sv
// Bus bundle for the MMX writeback arbiter: two writeback requesters, the
// destination-reservation port, the hazard-check port and the register file write port.
interface mmx_wb_arbiter_if;
    logic        a_valid;
    logic [2:0]  a_reg;
    logic [63:0] a_data;
    logic        a_ready;

    logic        b_valid;
    logic [2:0]  b_reg;
    logic [63:0] b_data;
    logic        b_ready;

    logic        alloc_en;
    logic [2:0]  alloc_reg;
    logic        alloc_ready;

    logic [2:0]  rd_mm1;
    logic [2:0]  rd_mm2;
    logic        rd_stall;

    logic        wr_en;
    logic [2:0]  wr_reg;
    logic [63:0] wr_data;

    logic [7:0]  busy;
    logic        underflow_err;

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  alloc_en, alloc_reg, rd_mm1, rd_mm2,
        output a_ready, b_ready, alloc_ready, rd_stall,
        output wr_en, wr_reg, wr_data, busy, underflow_err
    );

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output alloc_en, alloc_reg, rd_mm1, rd_mm2,
        input  a_ready, b_ready, alloc_ready, rd_stall,
        input  wr_en, wr_reg, wr_data, busy, underflow_err
    );
endinterface

// File: rtl/mmx_wb_arbiter.sv
// Round-robin writeback arbiter for the MMX register file, with a per-register
// pending-write scoreboard that drives source-operand hazard stalls.
module mmx_wb_arbiter (
    input logic             clk,
    input logic             rst,
    mmx_wb_arbiter_if.slave bus
);

    logic        last_b;
    logic        grant_a;
    logic        grant_b;

    logic        wr_en_q;
    logic [2:0]  wr_reg_q;
    logic [63:0] wr_data_q;

    logic [1:0]  cnt     [8];
    logic [1:0]  cnt_nxt [8];
    logic [7:0]  inc_vec;
    logic [7:0]  dec_vec;
    logic [7:0]  busy_vec;
    logic        alloc_fire;
    logic        underflow_q;
    logic        underflow_nxt;

    // Ties go to whichever requester did not win the last transfer; no grant in reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (bus.a_valid && (!bus.b_valid || last_b)) grant_a = 1'b1;
            else if (bus.b_valid)                        grant_b = 1'b1;
        end
    end

    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b    <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= 3'd0;
            wr_data_q <= 64'd0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            wr_en_q <= grant_a | grant_b;
            if (grant_a) begin
                wr_reg_q  <= bus.a_reg;
                wr_data_q <= bus.a_data;
                last_b    <= 1'b0;
            end else if (grant_b) begin
                wr_reg_q  <= bus.b_reg;
                wr_data_q <= bus.b_data;
                last_b    <= 1'b1;
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_reg  = wr_reg_q;
    assign bus.wr_data = wr_data_q;

    assign bus.alloc_ready = (cnt[bus.alloc_reg] != 2'd3);
    assign alloc_fire      = bus.alloc_en & bus.alloc_ready;
    assign inc_vec         = alloc_fire ? (8'd1 << bus.alloc_reg) : 8'd0;
    assign dec_vec         = wr_en_q    ? (8'd1 << wr_reg_q)      : 8'd0;

    // An allocate and a commit hitting the same register cancel out.
    always_comb begin
        underflow_nxt = underflow_q;
        for (int n = 0; n < 8; n++) begin
            cnt_nxt[n]  = cnt[n];
            busy_vec[n] = (cnt[n] != 2'd0);
            if (inc_vec[n] && !dec_vec[n]) begin
                cnt_nxt[n] = cnt[n] + 2'd1;
            end else if (dec_vec[n] && !inc_vec[n]) begin
                if (cnt[n] == 2'd0) underflow_nxt = 1'b1;
                else                cnt_nxt[n]    = cnt[n] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is only eight flop pairs, so it is reset like any other state.
            for (int n = 0; n < 8; n++) cnt[n] <= 2'd0;
            underflow_q <= 1'b0;
        end else begin
            for (int n = 0; n < 8; n++) cnt[n] <= cnt_nxt[n];
            underflow_q <= underflow_nxt;
        end
    end

    assign bus.busy          = busy_vec;
    assign bus.underflow_err = underflow_q;
    assign bus.rd_stall      = busy_vec[bus.rd_mm1] | busy_vec[bus.rd_mm2];

endmodule

// File: tb/tb_mmx_wb_arbiter.sv
// Directed self-checking bench for mmx_wb_arbiter: arbitration order, writeback
// latency, scoreboard counting, underflow and reset behaviour.
module tb_mmx_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [63:0] DATA_A = 64'h1111_1111_1111_1111;
    localparam logic [63:0] DATA_B = 64'h2222_2222_2222_2222;

    mmx_wb_arbiter_if bus ();

    mmx_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.a_valid = 1'b1; bus.a_reg = 3'd2; bus.a_data = DATA_A;
        bus.b_valid = 1'b1; bus.b_reg = 3'd5; bus.b_data = DATA_B;
        bus.alloc_en = 1'b0; bus.alloc_reg = 3'd0;
        bus.rd_mm1 = 3'd0; bus.rd_mm2 = 3'd0;

        // Reset state, with both requesters already pushing.
        tick(); tick();
        check("rst_wr_en",     bus.wr_en, 0);
        check("rst_wr_reg",    bus.wr_reg, 0);
        check("rst_wr_data",   bus.wr_data, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_underflow", bus.underflow_err, 0);
        check("rst_a_ready",   bus.a_ready, 0);
        check("rst_b_ready",   bus.b_ready, 0);

        // First contention after reset goes to A, then B.
        rst = 1'b0;
        #1;
        check("c1_a_ready", bus.a_ready, 1);
        check("c1_b_ready", bus.b_ready, 0);
        tick();
        check("c2_wr_en",   bus.wr_en, 1);
        check("c2_wr_reg",  bus.wr_reg, 2);
        check("c2_wr_data", bus.wr_data, DATA_A);
        check("c2_b_ready", bus.b_ready, 1);
        check("c2_a_ready", bus.a_ready, 0);
        tick();
        check("c3_wr_en",   bus.wr_en, 1);
        check("c3_wr_reg",  bus.wr_reg, 5);
        check("c3_wr_data", bus.wr_data, DATA_B);

        // Held contention alternates A,B,A,B,A,B with back-to-back writes.
        for (int i = 0; i < 6; i++) begin
            check("alt_a_ready", bus.a_ready, (i % 2 == 0) ? 1 : 0);
            check("alt_b_ready", bus.b_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            check("alt_wr_en",  bus.wr_en, 1);
            check("alt_wr_reg", bus.wr_reg, (i % 2 == 0) ? 2 : 5);
        end

        // Idle: write port holds last values; unreserved commits raised underflow.
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        tick();
        check("idle_wr_en",     bus.wr_en, 0);
        check("idle_wr_reg",    bus.wr_reg, 5);
        check("idle_wr_data",   bus.wr_data, DATA_B);
        check("idle_underflow", bus.underflow_err, 1);
        check("idle_busy",      bus.busy, 0);

        // Pointer moves only on transfers: B alone, idle, then contention -> A.
        bus.b_valid = 1'b1;
        #1;
        check("solo_b_ready", bus.b_ready, 1);
        tick();
        bus.b_valid = 1'b0;
        tick();
        tick();
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        #1;
        check("rr_after_idle_a", bus.a_ready, 1);
        check("rr_after_idle_b", bus.b_ready, 0);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;

        // Reset clears the sticky underflow.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_underflow", bus.underflow_err, 0);

        // Three reservations saturate MM3; a fourth is refused.
        bus.alloc_en = 1'b1; bus.alloc_reg = 3'd3;
        #1;
        check("alloc3_ready0", bus.alloc_ready, 1);
        tick(); tick(); tick();
        check("alloc3_busy",  bus.busy, 8'h08);
        check("alloc3_full",  bus.alloc_ready, 0);
        tick();
        bus.alloc_en = 1'b0;
        check("alloc3_busy4", bus.busy, 8'h08);

        // Three commits to MM3 drain it.
        bus.a_valid = 1'b1; bus.a_reg = 3'd3;
        tick(); tick(); tick();
        bus.a_valid = 1'b0;
        check("drain3_partial", bus.busy, 8'h08);
        tick();
        check("drain3_wr_reg", bus.wr_reg, 3);
        check("drain3_busy",   bus.busy, 8'h00);
        check("drain3_uf",     bus.underflow_err, 0);
        tick();
        check("drain3_idle",   bus.wr_en, 0);

        // Allocate and commit MM4 in the same cycle: count stays at 1.
        bus.alloc_en = 1'b1; bus.alloc_reg = 3'd4;
        tick();
        bus.alloc_en = 1'b0;
        bus.a_valid = 1'b1; bus.a_reg = 3'd4;
        tick();
        bus.a_valid = 1'b0;
        bus.alloc_en = 1'b1; bus.alloc_reg = 3'd4;
        bus.rd_mm1 = 3'd4; bus.rd_mm2 = 3'd0;
        #1;
        check("same4_commit", bus.wr_en, 1);
        tick();
        bus.alloc_en = 1'b0;
        check("same4_busy",  bus.busy, 8'h10);
        check("same4_stall", bus.rd_stall, 1);
        check("same4_uf",    bus.underflow_err, 0);
        bus.rd_mm1 = 3'd1; bus.rd_mm2 = 3'd4;
        #1;
        check("stall_mm2", bus.rd_stall, 1);
        bus.rd_mm2 = 3'd0;
        #1;
        check("no_stall", bus.rd_stall, 0);
        bus.b_valid = 1'b1; bus.b_reg = 3'd4;
        tick();
        bus.b_valid = 1'b0;
        tick();
        check("drain4_busy", bus.busy, 8'h00);

        // Commit to an unreserved MM6 sets the sticky underflow.
        bus.a_valid = 1'b1; bus.a_reg = 3'd6;
        tick();
        bus.a_valid = 1'b0;
        tick();
        check("uf6_set",  bus.underflow_err, 1);
        check("uf6_busy", bus.busy, 8'h00);
        tick(); tick();
        check("uf6_sticky", bus.underflow_err, 1);

        // Reset mid-stream kills the write and the scoreboard at once.
        bus.alloc_en = 1'b1; bus.alloc_reg = 3'd7;
        tick(); tick();
        bus.alloc_en = 1'b0;
        check("pre_rst_busy", bus.busy, 8'h80);
        bus.a_valid = 1'b1; bus.a_reg = 3'd1; bus.a_data = 64'hDEAD_BEEF_0000_0001;
        tick();
        check("pre_rst_wr_en", bus.wr_en, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en",   bus.wr_en, 0);
        check("mid_rst_wr_reg",  bus.wr_reg, 0);
        check("mid_rst_wr_data", bus.wr_data, 0);
        check("mid_rst_busy",    bus.busy, 8'h00);
        check("mid_rst_uf",      bus.underflow_err, 0);
        check("mid_rst_a_ready", bus.a_ready, 0);
        tick();
        check("rst_edge_wr_en", bus.wr_en, 0);
        rst = 1'b0;
        bus.a_valid = 1'b0;
        tick();
        check("post_rst_wr_en1", bus.wr_en, 0);
        tick();
        check("post_rst_wr_en2", bus.wr_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
